// File: rtl/gpr_writeback_queue_if.sv
// Bundle of the writeback-queue ports: main-path writeback, MDU handshake,
// register-file write port, decode forwarding and status.
interface gpr_writeback_queue_if #(
  parameter int CW = 3
) ();
  logic          wbValid;
  logic [0:4]    wbDst;
  logic [0:31]   wbData;
  logic          mduValid;
  logic [0:4]    mduDst;
  logic [0:31]   mduData;
  logic          mduReady;
  logic          regWr;
  logic [0:4]    Rw;
  logic [0:31]   busW;
  logic [0:4]    Rs;
  logic [0:4]    Rt;
  logic          fwdAHit;
  logic          fwdBHit;
  logic [0:31]   fwdA;
  logic [0:31]   fwdB;
  logic [0:CW-1] qCount;
  logic          drainIdle;

  // Pipeline side: offers writebacks/MDU results and decode addresses.
  modport master (
    output wbValid, wbDst, wbData, mduValid, mduDst, mduData, Rs, Rt,
    input  mduReady, regWr, Rw, busW, fwdAHit, fwdBHit, fwdA, fwdB, qCount, drainIdle
  );

  // Queue side.
  modport slave (
    input  wbValid, wbDst, wbData, mduValid, mduDst, mduData, Rs, Rt,
    output mduReady, regWr, Rw, busW, fwdAHit, fwdBHit, fwdA, fwdB, qCount, drainIdle
  );
endinterface

// File: rtl/gpr_writeback_queue.sv
// Merges main-path writebacks and queued MDU results onto the single
// register-file write port. Main path always wins the slot; MDU results wait
// in a FIFO and are forwarded to decode while queued. A main-path write kills
// older queued entries for the same register so they are later dropped.
module gpr_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic                  clk,
  input logic                  reset,
  gpr_writeback_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic        live;
    logic [4:0]  dst;
    logic [31:0] data;
  } entry_t;

  entry_t        q [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          wr_q;
  logic [4:0]    rw_q;
  logic [31:0]   busw_q;
  logic          wb_wr, push, store, pop;

  // A main-path write to r0 is not a write, so the queue may drain that cycle.
  assign wb_wr         = bus.wbValid && (bus.wbDst != 5'd0);
  // Space is judged on the current count; a same-cycle pop does not free a slot.
  assign bus.mduReady  = !reset && (count < CW'(DEPTH));
  assign push          = bus.mduValid && bus.mduReady;
  assign store         = push && (bus.mduDst != 5'd0);
  assign pop           = !wb_wr && (count != '0);

  assign bus.regWr     = wr_q;
  assign bus.Rw        = rw_q;
  assign bus.busW      = busw_q;
  assign bus.qCount    = count;
  assign bus.drainIdle = (count == '0) && !wr_q;

  // Queue storage: kill on main-path WAW, clear on pop, then append the push.
  // The push is written last so a same-cycle entry for wbDst stays live.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wb_wr) begin
        for (int i = 0; i < DEPTH; i++)
          if (q[i].dst == bus.wbDst) q[i].live <= 1'b0;
      end
      if (pop) begin
        q[head].live <= 1'b0;
        head         <= head + PW'(1);
      end
      if (store) begin
        q[tail] <= '{live: 1'b1, dst: bus.mduDst, data: bus.mduData};
        tail    <= tail + PW'(1);
      end
      count <= count + CW'(store) - CW'(pop);
    end
  end

  // Register-file write slot: main path first, else the queue head.
  // Address/data hold whenever no write is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= 1'b0;
      rw_q   <= '0;
      busw_q <= '0;
    end else if (wb_wr) begin
      wr_q   <= 1'b1;
      rw_q   <= bus.wbDst;
      busw_q <= bus.wbData;
    end else if (pop) begin
      wr_q <= q[head].live;
      if (q[head].live) begin
        rw_q   <= q[head].dst;
        busw_q <= q[head].data;
      end
    end else begin
      wr_q <= 1'b0;
    end
  end

  // Decode forwarding: scan oldest to youngest so the youngest live match wins.
  always_comb begin
    bus.fwdAHit = 1'b0;
    bus.fwdA    = '0;
    bus.fwdBHit = 1'b0;
    bus.fwdB    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) && q[head + PW'(k)].live) begin
        if ((bus.Rs != 5'd0) && (q[head + PW'(k)].dst == bus.Rs)) begin
          bus.fwdAHit = 1'b1;
          bus.fwdA    = q[head + PW'(k)].data;
        end
        if ((bus.Rt != 5'd0) && (q[head + PW'(k)].dst == bus.Rt)) begin
          bus.fwdBHit = 1'b1;
          bus.fwdB    = q[head + PW'(k)].data;
        end
      end
    end
  end
endmodule

// File: tb/tb_gpr_writeback_queue.sv
// Bench for gpr_writeback_queue: directed vector table covering the main
// scenarios, then randomized traffic against a queue-based reference model.
module tb_gpr_writeback_queue;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gpr_writeback_queue_if #(.CW(CW)) bus ();
  gpr_writeback_queue #(.DEPTH(DEPTH), .CW(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit wv, input bit [4:0] wd, input bit [31:0] wdat,
                       input bit mv, input bit [4:0] md, input bit [31:0] mdat,
                       input bit [4:0] rs, input bit [4:0] rt);
    reset        = r;
    bus.wbValid  = wv;
    bus.wbDst    = wd;
    bus.wbData   = wdat;
    bus.mduValid = mv;
    bus.mduDst   = md;
    bus.mduData  = mdat;
    bus.Rs       = rs;
    bus.Rt       = rt;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit rst; bit wv; bit [4:0] wd; bit [31:0] wdat;
    bit mv; bit [4:0] md; bit [31:0] mdat; bit [4:0] rs;
    bit e_wr; bit [4:0] e_rw; bit [31:0] e_bus; int e_qc;
    bit e_rdy; bit e_idle; bit e_ha; bit [31:0] e_fa;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(bit rst, bit wv, bit [4:0] wd, bit [31:0] wdat,
                             bit mv, bit [4:0] md, bit [31:0] mdat, bit [4:0] rs,
                             bit e_wr, bit [4:0] e_rw, bit [31:0] e_bus, int e_qc,
                             bit e_rdy, bit e_idle, bit e_ha, bit [31:0] e_fa);
    vec_t t;
    t.rst = rst; t.wv = wv; t.wd = wd; t.wdat = wdat;
    t.mv = mv; t.md = md; t.mdat = mdat; t.rs = rs;
    t.e_wr = e_wr; t.e_rw = e_rw; t.e_bus = e_bus; t.e_qc = e_qc;
    t.e_rdy = e_rdy; t.e_idle = e_idle; t.e_ha = e_ha; t.e_fa = e_fa;
    return t;
  endfunction

  // ---------------- reference model ----------------
  typedef struct { bit live; bit [4:0] dst; bit [31:0] data; } ment_t;
  ment_t      mq[$];
  bit         m_wr;
  bit [4:0]   m_rw;
  bit [31:0]  m_bus;

  function automatic void mfwd(input bit [4:0] r, output bit h, output bit [31:0] d);
    h = 1'b0;
    d = '0;
    if (r != 0)
      foreach (mq[j])
        if (mq[j].live && mq[j].dst == r) begin
          h = 1'b1;
          d = mq[j].data;
        end
  endfunction

  task automatic rand_cycle(input bit r);
    bit wv, mv, rdy, ha, hb;
    bit [4:0] wd, md, rs, rt;
    bit [31:0] wdat, mdat, fa, fb;
    ment_t e;
    wv   = ($urandom_range(0, 9) < 4);
    wd   = 5'($urandom_range(0, 7));
    wdat = $urandom;
    mv   = ($urandom_range(0, 9) < 6);
    md   = 5'($urandom_range(0, 7));
    mdat = $urandom;
    rs   = 5'($urandom_range(0, 7));
    rt   = 5'($urandom_range(0, 7));
    drive(r, wv, wd, wdat, mv, md, mdat, rs, rt);
    #1;
    rdy = !r && (mq.size() < DEPTH);
    mfwd(rs, ha, fa);
    mfwd(rt, hb, fb);
    chk("rnd regWr",     bus.regWr,     m_wr);
    chk("rnd Rw",        bus.Rw,        m_rw);
    chk("rnd busW",      bus.busW,      m_bus);
    chk("rnd qCount",    bus.qCount,    mq.size());
    chk("rnd mduReady",  bus.mduReady,  rdy);
    chk("rnd drainIdle", bus.drainIdle, (mq.size() == 0) && !m_wr);
    chk("rnd fwdAHit",   bus.fwdAHit,   ha);
    chk("rnd fwdA",      bus.fwdA,      fa);
    chk("rnd fwdBHit",   bus.fwdBHit,   hb);
    chk("rnd fwdB",      bus.fwdB,      fb);
    if (r) begin
      mq.delete();
      m_wr = 0; m_rw = 0; m_bus = 0;
    end else begin
      if (wv && wd != 0) begin
        foreach (mq[j]) if (mq[j].dst == wd) mq[j].live = 0;
        m_wr = 1; m_rw = wd; m_bus = wdat;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_wr = e.live;
        if (e.live) begin m_rw = e.dst; m_bus = e.data; end
      end else begin
        m_wr = 0;
      end
      if (mv && rdy && md != 0) mq.push_back('{1'b1, md, mdat});
    end
    @(negedge clk);
  endtask

  initial begin
    bit [31:0] A, C, T;
    A = 32'h12345678; C = 32'hCAFEF00D; T = 32'h33333333;
    // reset, then main path alone
    tbl.push_back(v(0,0,0,0,        0,0,0,0,           0,0,0,0,          1,1,0,0));
    tbl.push_back(v(0,1,5,A,        0,0,0,0,           0,0,0,0,          1,1,0,0));
    tbl.push_back(v(0,0,0,0,        0,0,0,0,           1,5,A,0,          1,0,0,0));
    tbl.push_back(v(0,0,0,0,        0,0,0,0,           0,5,A,0,          1,1,0,0));
    // MDU through idle path
    tbl.push_back(v(0,0,0,0,        1,9,C,9,           0,5,A,0,          1,1,0,0));
    tbl.push_back(v(0,0,0,0,        0,0,0,9,           0,5,A,1,          1,0,1,C));
    tbl.push_back(v(0,0,0,0,        0,0,0,9,           1,9,C,0,          1,0,0,0));
    tbl.push_back(v(0,0,0,0,        0,0,0,0,           0,9,C,0,          1,1,0,0));
    // fill while main path holds the slot, then drain across the wrap
    tbl.push_back(v(0,1,3,T,        1,10,'h10A,0,      0,9,C,0,          1,1,0,0));
    tbl.push_back(v(0,1,3,T,        1,11,'h10B,0,      1,3,T,1,          1,0,0,0));
    tbl.push_back(v(0,1,3,T,        1,12,'h10C,0,      1,3,T,2,          1,0,0,0));
    tbl.push_back(v(0,1,3,T,        1,13,'h10D,0,      1,3,T,3,          1,0,0,0));
    tbl.push_back(v(0,1,3,T,        1,14,'h10E,0,      1,3,T,4,          0,0,0,0));
    tbl.push_back(v(0,0,0,0,        1,14,'h10E,0,      1,3,T,4,          0,0,0,0));
    tbl.push_back(v(0,0,0,0,        1,14,'h10E,0,      1,10,'h10A,3,     1,0,0,0));
    tbl.push_back(v(0,0,0,0,        0,0,0,0,           1,11,'h10B,3,     1,0,0,0));
    tbl.push_back(v(0,0,0,0,        0,0,0,0,           1,12,'h10C,2,     1,0,0,0));
    tbl.push_back(v(0,0,0,0,        0,0,0,0,           1,13,'h10D,1,     1,0,0,0));
    tbl.push_back(v(0,0,0,0,        0,0,0,0,           1,14,'h10E,0,     1,0,0,0));
    tbl.push_back(v(0,0,0,0,        0,0,0,0,           0,14,'h10E,0,     1,1,0,0));
    // WAW kill
    tbl.push_back(v(0,0,0,0,        1,7,'hAAAA0000,7,  0,14,'h10E,0,     1,1,0,0));
    tbl.push_back(v(0,1,7,'hBBBB0000,0,0,0,7,          0,14,'h10E,1,     1,0,1,'hAAAA0000));
    tbl.push_back(v(0,0,0,0,        0,0,0,7,           1,7,'hBBBB0000,1, 1,0,0,0));
    tbl.push_back(v(0,0,0,0,        0,0,0,7,           0,7,'hBBBB0000,0, 1,1,0,0));
    // same-cycle push with the same dst survives the kill
    tbl.push_back(v(0,1,6,'h66,     1,6,'h77,6,        0,7,'hBBBB0000,0, 1,1,0,0));
    tbl.push_back(v(0,0,0,0,        0,0,0,6,           1,6,'h66,1,       1,0,1,'h77));
    tbl.push_back(v(0,0,0,0,        0,0,0,0,           1,6,'h77,0,       1,0,0,0));
    tbl.push_back(v(0,0,0,0,        0,0,0,0,           0,6,'h77,0,       1,1,0,0));
    // r0 push, youngest-match forwarding, Rs=0
    tbl.push_back(v(0,1,1,'h11,     1,0,'hDEAD,0,      0,6,'h77,0,       1,1,0,0));
    tbl.push_back(v(0,1,1,'h11,     1,4,1,0,           1,1,'h11,0,       1,0,0,0));
    tbl.push_back(v(0,1,1,'h11,     1,4,2,4,           1,1,'h11,1,       1,0,1,1));
    tbl.push_back(v(0,1,1,'h11,     0,0,0,4,           1,1,'h11,2,       1,0,1,2));
    tbl.push_back(v(0,1,1,'h11,     0,0,0,0,           1,1,'h11,2,       1,0,0,0));
    // reset mid-operation with 3 entries queued
    tbl.push_back(v(0,1,1,'h11,     1,20,'h20,0,       1,1,'h11,2,       1,0,0,0));
    tbl.push_back(v(1,1,1,'h11,     1,21,'h21,20,      1,1,'h11,3,       0,0,1,'h20));
    tbl.push_back(v(0,0,0,0,        0,0,0,20,          0,0,0,0,          1,1,0,0));
    tbl.push_back(v(0,0,0,0,        0,0,0,0,           0,0,0,0,          1,1,0,0));
    tbl.push_back(v(0,0,0,0,        0,0,0,0,           0,0,0,0,          1,1,0,0));

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].wv, tbl[i].wd, tbl[i].wdat,
            tbl[i].mv, tbl[i].md, tbl[i].mdat, tbl[i].rs, 5'd0);
      #1;
      chk($sformatf("row%0d regWr", i),     bus.regWr,     tbl[i].e_wr);
      chk($sformatf("row%0d Rw", i),        bus.Rw,        tbl[i].e_rw);
      chk($sformatf("row%0d busW", i),      bus.busW,      tbl[i].e_bus);
      chk($sformatf("row%0d qCount", i),    bus.qCount,    tbl[i].e_qc);
      chk($sformatf("row%0d mduReady", i),  bus.mduReady,  tbl[i].e_rdy);
      chk($sformatf("row%0d drainIdle", i), bus.drainIdle, tbl[i].e_idle);
      chk($sformatf("row%0d fwdAHit", i),   bus.fwdAHit,   tbl[i].e_ha);
      chk($sformatf("row%0d fwdA", i),      bus.fwdA,      tbl[i].e_fa);
      @(negedge clk);
    end

    // randomized traffic; the first cycle resets the DUT and the model together
    mq.delete();
    m_wr = 0; m_rw = 0; m_bus = 0;
    for (int i = 0; i < 3000; i++)
      rand_cycle((i == 0) || ($urandom_range(0, 199) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/gpr_writeback_queue.md
# gpr_writeback_queue

Write-side sequencer for the general-purpose register file. It merges single-cycle writebacks from the main datapath with long-latency results from the multiply/divide unit (MDU) onto the register file's single write port (`regWr`/`Rw`/`busW`). MDU results are held in a small FIFO until a free write slot exists. Decode gets forwarding of queued, not-yet-written values.

## Interface
- `DEPTH`, 4: MDU queue entries; power of two, ≥2
- `CW`, 3: count width, log2(DEPTH)+1

- `clk` in 1: single clock; all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `wbValid` in 1: main-path writeback this cycle; never stalled
- `wbDst` in [0:4]: main-path destination register
- `wbData` in [0:31]: main-path result
- `mduValid` in 1: MDU result offered
- `mduDst` in [0:4]: MDU destination register
- `mduData` in [0:31]: MDU result
- `mduReady` out 1: queue can accept; transfer occurs when `mduValid && mduReady` at an edge
- `regWr` out 1: register-file write enable (registered)
- `Rw` out [0:4]: register-file write address (registered)
- `busW` out [0:31]: register-file write data (registered)
- `Rs`, `Rt` in [0:4]: decode read addresses
- `fwdAHit`, `fwdBHit` out 1: a live queued entry matches `Rs` / `Rt`
- `fwdA`, `fwdB` out [0:31]: data of the youngest live matching entry; 0 when no hit
- `qCount` out [0:CW-1]: occupied entries, including killed ones
- `drainIdle` out 1: queue empty and `regWr`==0

## Operation
- Queue entry fields: `live`, `dst`, `data`. FIFO order, with head and tail pointers that wrap modulo DEPTH.
- **Push:** on a transfer, an entry is written at the tail with `live`=1.
  - `mduDst`==0 completes the handshake but stores nothing.
- **Output slot, evaluated every cycle in priority order:**
  1. `wbValid && wbDst!=0`: next `regWr`=1, `Rw`=`wbDst`, `busW`=`wbData`. No pop.
  2. Otherwise, queue non-empty: pop the head.
     - Head `live`=1: next `regWr`=1, `Rw`/`busW` from the head.
     - Head `live`=0: next `regWr`=0; the killed entry is discarded.
  3. Otherwise, next `regWr`=0.
  - `Rw`/`busW` hold their previous values whenever `regWr`=0.
- `wbValid` with `wbDst`==0 counts as no write, so the queue may drain that cycle.
- **WAW kill:**
  - When `wbValid && wbDst!=0`, every queued entry with `dst`==`wbDst` gets `live`←0 at that edge. The newer main-path value wins.
  - An entry pushed in the same cycle with the same `dst` is NOT killed; it is younger.
- **Forwarding:** combinational over live queue entries only.
  - The youngest matching entry wins.
  - `Rs`/`Rt`==0 never hits.
  - The output register and the main path are not forwarded.
- **`mduReady`:** `qCount < DEPTH`, computed from the current count. A same-cycle pop does not free space for a same-cycle push. Forced to 0 while `reset`=1.
- **`qCount` arithmetic:** next = count + push − pop. Never exceeds DEPTH and never underflows.

## Timing
- Reset (one edge with `reset`=1):
  - count 0, pointers 0, all `live` 0
  - `regWr` 0, `Rw` 0, `busW` 0
  - pushes and writebacks in that cycle are ignored
  - After reset: `mduReady`=1, `drainIdle`=1, `fwd*Hit`=0.
- Reset mid-operation discards all queued entries; no write to the register file is issued for them.
- Main-path latency: 1 edge from `wbValid` to `regWr`. Outputs are stable through the following falling edge, where the register file samples them.
- MDU latency: minimum 2 edges, accept→queue then pop→`regWr`. Longer while the main path occupies the slot.
- Full queue with a simultaneous pop: the push is refused (`mduReady`=0), and the count drops by 1 that edge.
- Wrap-around: pointers wrap silently; FIFO order is preserved across the wrap.
- Continuous `wbValid` starves the queue indefinitely. This is intended: control raises stalls based on `drainIdle`.

## Test plan
- **Reset, then main path alone:** `wbValid`=1, `wbDst`=5, `wbData`=0x12345678 → next cycle `regWr`=1, `Rw`=5, `busW`=0x12345678. Following cycle, with the input idle, `regWr`=0.
- **MDU through an idle path:** push (`mduDst`=9, 0xCAFEF00D) → `qCount`=1, `fwdAHit`=1 with `Rs`=9. One cycle later `regWr`=1, `Rw`=9; `qCount`=0, `drainIdle`=1 the cycle after.
- **Fill and starve:**
  - Hold `wbValid`=1 (dst 3) while pushing 5 MDU results (dst 10–14) → `mduReady`=0 after 4; the fifth waits.
  - Release `wbValid` → writes 10, 11, 12, 13 on consecutive cycles, then 14; FIFO order holds across pointer wrap.
- **WAW kill:**
  - Queue dst 7 = 0xAAAA0000.
  - Main-path write dst 7 = 0xBBBB0000 → `regWr` with 0xBBBB0000. The queued entry is popped later with `regWr`=0, and `fwdAHit` for `Rs`=7 drops at the kill edge.
- **Register zero and youngest-match forwarding:**
  - `mduDst`=0 is accepted but `qCount` is unchanged.
  - Queue dst 4 = 1, then dst 4 = 2 → `Rs`=4 gives `fwdA`=2.
  - `Rs`=0 never hits.
- **Reset mid-operation:** with 3 entries queued, assert `reset` for one edge → `qCount`=0, `regWr`=0, `Rw`=0, `busW`=0; no queued write is ever issued.
